mastermind_top: RTL and testbench

//   Scoring core for a 4-digit hex code-breaking game (Mastermind-style).
//   - Secret code: four 4-bit digits captured from board switches.
//   - Each guess is scored as exact hits (right digit, right place) and

---
 rtl/mastermind_pkg.sv | 15 +
 rtl/mastermind_scorer.sv | 45 ++++
 rtl/mastermind_top.sv | 50 +++++
 tb/tb_mastermind_top.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared sizing and digit helpers for the code-breaking scoring core.
// Digit 1 is the most significant nibble of a packed code word.
package mastermind_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int CODE_W  = DIGITS * DIGIT_W;
    localparam int CNT_W   = 4;

    function automatic logic [DIGIT_W-1:0] get_digit(input logic [CODE_W-1:0] word,
                                                     input int                idx);
        return word[CODE_W-1-idx*DIGIT_W -: DIGIT_W];
    endfunction

endpackage

// File: rtl/mastermind_scorer.sv
// Combinational scorer: exact hits first, then greedy partial matching
// where every secret digit can be claimed by at most one guess digit.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic [CODE_W-1:0] secret,
    input  logic [CODE_W-1:0] guess,
    output logic [CNT_W-1:0]  correct,
    output logic [CNT_W-1:0]  wrong
);

    logic [DIGITS-1:0] w_exact;

    always_comb begin
        w_exact = '0;
        for (int i = 0; i < DIGITS; i++)
            w_exact[i] = (get_digit(secret, i) == get_digit(guess, i));
    end

    always_comb begin
        logic [DIGITS-1:0] sec_used;
        logic              found;
        correct  = '0;
        wrong    = '0;
        sec_used = w_exact;
        found    = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (w_exact[i]) correct = correct + 1'b1;
        // Exact positions are already consumed on both sides.
        for (int g = 0; g < DIGITS; g++) begin
            found = 1'b0;
            if (!w_exact[g]) begin
                for (int s = 0; s < DIGITS; s++) begin
                    if (!found && !sec_used[s] &&
                        get_digit(secret, s) == get_digit(guess, g)) begin
                        sec_used[s] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
            if (found) wrong = wrong + 1'b1;
        end
    end

endmodule

// File: rtl/mastermind_top.sv
// Game top: registers the switch secret, scores the live guess against it
// and registers both hit counts. Only the default sizing is supported.
module mastermind_top
    import mastermind_pkg::*;
#(
    parameter int P_DIGITS  = DIGITS,
    parameter int P_DIGIT_W = DIGIT_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [P_DIGIT_W-1:0]            switches1,
    input  logic [P_DIGIT_W-1:0]            switches2,
    input  logic [P_DIGIT_W-1:0]            switches3,
    input  logic [P_DIGIT_W-1:0]            switches4,
    input  logic [P_DIGITS*P_DIGIT_W-1:0]   guess,
    output logic [P_DIGITS*P_DIGIT_W-1:0]   secret_number,
    output logic [CNT_W-1:0]                wrong_place_count,
    output logic [CNT_W-1:0]                correct_place_count
);

    logic [CODE_W-1:0] r_secret;
    logic [CNT_W-1:0]  r_correct;
    logic [CNT_W-1:0]  r_wrong;
    logic [CNT_W-1:0]  w_correct;
    logic [CNT_W-1:0]  w_wrong;

    mastermind_scorer u_scorer (
        .secret  (r_secret),
        .guess   (guess),
        .correct (w_correct),
        .wrong   (w_wrong)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_secret  <= '0;
            r_correct <= '0;
            r_wrong   <= '0;
        end else begin
            r_secret  <= {switches1, switches2, switches3, switches4};
            r_correct <= w_correct;
            r_wrong   <= w_wrong;
        end
    end

    assign secret_number       = r_secret;
    assign correct_place_count = r_correct;
    assign wrong_place_count   = r_wrong;

endmodule

// File: tb/tb_mastermind_top.sv
// Scoreboard bench: each stimulus cycle queues the outputs expected after
// the next edge; a monitor pops and compares once that edge has passed.
module tb_mastermind_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  switches1, switches2, switches3, switches4;
    logic [15:0] guess;
    logic [15:0] secret_number;
    logic [3:0]  wrong_place_count;
    logic [3:0]  correct_place_count;

    typedef struct {
        int          cyc;
        logic [15:0] sec;
        logic [3:0]  c;
        logic [3:0]  w;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    mastermind_top dut (
        .clk                 (clk),
        .reset               (reset),
        .switches1           (switches1),
        .switches2           (switches2),
        .switches3           (switches3),
        .switches4           (switches4),
        .guess               (guess),
        .secret_number       (secret_number),
        .wrong_place_count   (wrong_place_count),
        .correct_place_count (correct_place_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int at, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s edge=%0d got=%h want=%h", name, at, got, want);
    endtask

    // Monitor: after each edge, compare every expectation due by now.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    n_checks++;
                    $display("FAIL stale_expect edge=%0d got=%0d want=%0d", e.cyc, cyc, e.cyc);
                end else begin
                    check("secret_number", cyc, secret_number, e.sec);
                    check("correct_place_count", cyc, {12'h0, correct_place_count}, {12'h0, e.c});
                    check("wrong_place_count", cyc, {12'h0, wrong_place_count}, {12'h0, e.w});
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [15:0] sw, input logic [15:0] g,
                        input logic [15:0] sec, input logic [3:0] c, input logic [3:0] w);
        exp_t e;
        @(negedge clk);
        reset = rst;
        {switches1, switches2, switches3, switches4} = sw;
        guess = g;
        e.cyc = cyc + 1;
        e.sec = sec;
        e.c   = c;
        e.w   = w;
        q.push_back(e);
    endtask

    initial begin
        exp_t e0;
        reset = 1'b1;
        {switches1, switches2, switches3, switches4} = 16'hA2C1;
        guess = 16'hB948;
        e0.cyc = 1; e0.sec = 16'h0; e0.c = 4'd0; e0.w = 4'd0;
        q.push_back(e0);

        step(1, 16'hA2C1, 16'hB948, 16'h0000, 0, 0);
        step(0, 16'hA2C1, 16'hB948, 16'hA2C1, 0, 0);
        step(0, 16'hA2C1, 16'hB948, 16'hA2C1, 0, 0);
        step(0, 16'hA2C1, 16'hB9A4, 16'hA2C1, 0, 1);
        step(0, 16'hA2C1, 16'hBA4C, 16'hA2C1, 0, 2);
        // Mid-game reset held five edges.
        for (int i = 0; i < 5; i++) step(1, 16'hA2C1, 16'hBA4C, 16'h0000, 0, 0);
        step(0, 16'hA2C1, 16'hBA4C, 16'hA2C1, 0, 0);
        step(0, 16'hA2C1, 16'hBA4C, 16'hA2C1, 0, 2);
        step(0, 16'h3DE7, 16'h37ED, 16'h3DE7, 0, 0);
        step(0, 16'h3DE7, 16'h37ED, 16'h3DE7, 2, 2);
        // Switch latency: counts unchanged one edge after, updated two after.
        step(0, 16'h3DE7, 16'h2211, 16'h3DE7, 0, 0);
        step(0, 16'h1122, 16'h2211, 16'h1122, 0, 0);
        step(0, 16'h1122, 16'h2211, 16'h1122, 0, 4);
        step(0, 16'h1111, 16'h2211, 16'h1111, 0, 4);
        step(0, 16'h1111, 16'h2211, 16'h1111, 2, 0);
        // Guess latency: one edge.
        step(0, 16'h1111, 16'h1222, 16'h1111, 1, 0);
        step(0, 16'h1111, 16'h1111, 16'h1111, 4, 0);
        step(0, 16'h3DE7, 16'h3DE7, 16'h3DE7, 0, 0);
        step(0, 16'h3DE7, 16'h3DE7, 16'h3DE7, 4, 0);
        step(0, 16'h0050, 16'h0500, 16'h0050, 0, 0);
        step(0, 16'h0050, 16'h0500, 16'h0050, 2, 2);
        step(0, 16'h1121, 16'h2111, 16'h1121, 0, 0);
        step(0, 16'h1121, 16'h2111, 16'h1121, 2, 2);
        step(0, 16'h1234, 16'h4444, 16'h1234, 0, 0);
        step(0, 16'h1234, 16'h4444, 16'h1234, 1, 0);

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            $display("FAIL unchecked_expect edge=%0d got=none want=checked", e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
